seq_detect_ctrl: RTL and testbench
==================================

SEQ_DETECT_CTRL -- requirements
Module: seq_detect_ctrl

Interface
REQ-001 Parameter PAT_W, default 8, maximum pattern length in bits.
REQ-002 Parameter CNT_W, default 8, width of match counter and target.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 cfg_valid  input  1  configuration offer.
REQ-006 cfg_ready  output  1  configuration accepted this cycle if cfg_valid also high.
REQ-007 cfg_pattern  input  PAT_W  pattern; bit 0 = most recent bit of sequence.
REQ-008 cfg_len  input  $clog2(PAT_W)+1  pattern length, legal 1..PAT_W.
REQ-009 cfg_overlap  input  1  1 = overlapping matches allowed.
REQ-010 cfg_target  input  CNT_W  match count that ends a run; 0 = unlimited.
REQ-011 start  input  1  arm detector (single-cycle pulse).
REQ-012 abort  input  1  stop run, return to IDLE.
REQ-013 bit_valid  input  1  bit_in qualifier.
REQ-014 bit_in  input  1  serial data bit.
REQ-015 busy  output  1  high in ARMED.
REQ-016 match_pulse  output  1  one-cycle match indication.
REQ-017 match_count  output  CNT_W  matches in current run.
REQ-018 done  output  1  high in DONE.
REQ-019 err_cfg  output  1  sticky configuration error.

Function
REQ-020 FSM states IDLE, ARMED, DONE; rst -> IDLE.
REQ-021 cfg_ready = 1 in IDLE and DONE, 0 in ARMED.
REQ-022 Handshake cfg_valid&cfg_ready with cfg_len in 1..PAT_W: store pattern/len/overlap/target, set cfg_loaded, clear err_cfg.
REQ-023 Handshake with cfg_len 0 or >PAT_W: stored config unchanged, err_cfg set.
REQ-024 start in IDLE/DONE with cfg_loaded=1 -> ARMED next cycle; history, fill counter, match_count cleared.
REQ-025 start with cfg_loaded=0: ignored, err_cfg set.
REQ-026 abort in any state -> IDLE next cycle; match_count cleared; abort wins over start, cfg handshake still honored.
REQ-027 ARMED, bit_valid=1: bit_in shifted into history LSB, fill counter increments saturating at PAT_W; no shift when bit_valid=0.
REQ-028 Match condition: fill >= len and low len bits of post-shift history equal low len bits of pattern; bits above len ignored.
REQ-029 Moore timing: match_pulse registered, high exactly the cycle after the completing bit's bit_valid edge; never high outside ARMED-originated matches.
REQ-030 match_count increments on same edge match_pulse rises; saturates at 2^CNT_W-1.
REQ-031 cfg_overlap=0: fill counter reset to 0 on match, next match requires len fresh bits.
REQ-032 cfg_target!=0 and incremented count == target -> DONE on same edge; further bits ignored.
REQ-033 DONE holds match_count and done until start or abort.

Reset
REQ-034 rst: state IDLE, busy=0, match_pulse=0, match_count=0, done=0, err_cfg=0, cfg_loaded=0, history=0, fill=0.
REQ-035 rst mid-run takes priority over all inputs and discards stored config.

Structure
REQ-036 Package seq_detect_pkg holds FSM state enum and default PAT_W/CNT_W constants.
REQ-037 One sub-module seq_matcher: history shift register, fill counter, masked compare; controller owns FSM, counter, config regs.

Verification
REQ-038 cfg 10101 len 5 overlap 1 target 0, start, stream 1010101 -> match_pulse one cycle after 5th and 7th bits, match_count=2.
REQ-039 Same stream, overlap 0 -> single match after 5th bit, match_count=1.
REQ-040 target 2, pattern 11 len 2 overlap 1, stream 111 -> done after 3rd bit+1 cycle, busy=0, 4th bit ignored, count=2.
REQ-041 cfg_len 0 offered, then start -> err_cfg=1, state stays IDLE; valid cfg then clears err_cfg.
REQ-042 abort and start same cycle in ARMED -> IDLE, match_count=0, busy=0.
REQ-043 bit_valid gaps: pattern 101 bits with idle cycles between -> one match, pulse one cycle after last valid bit.

Source files
------------

// File: rtl/seq_detect_pkg.sv
// Shared types and default sizes for the serial sequence detector.
package seq_detect_pkg;

  localparam int DEF_PAT_W = 8;
  localparam int DEF_CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/seq_detect_ctrl_if.sv
// Configuration channel of the sequence detector.
// Handshake: a configuration transfers on a rising clk edge where cfg_valid
// and cfg_ready are both high; cfg_pattern/cfg_len/cfg_overlap/cfg_target are
// sampled on that edge only. cfg_ready does not depend on cfg_valid.
interface seq_detect_ctrl_if #(
  parameter int PAT_W = 8,
  parameter int CNT_W = 8
) ();

  logic                   cfg_valid;
  logic                   cfg_ready;
  logic [PAT_W-1:0]       cfg_pattern;
  logic [$clog2(PAT_W):0] cfg_len;
  logic                   cfg_overlap;
  logic [CNT_W-1:0]       cfg_target;

  modport master (
    output cfg_valid, cfg_pattern, cfg_len, cfg_overlap, cfg_target,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_pattern, cfg_len, cfg_overlap, cfg_target,
    output cfg_ready
  );

endinterface

// File: rtl/seq_matcher.sv
// History shift register, fill counter and masked pattern compare.
// hit is combinational and refers to the history as it will be after
// the current bit is shifted in.
module seq_matcher #(
  parameter int PAT_W = 8,
  parameter int LEN_W = $clog2(PAT_W) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             shift_en,
  input  logic             bit_in,
  input  logic             overlap,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  output logic             hit
);

  logic [PAT_W-1:0] hist_q;
  logic [PAT_W-1:0] hist_next;
  logic [LEN_W-1:0] fill_q;
  logic [LEN_W-1:0] fill_inc;
  logic [PAT_W-1:0] mask;

  assign hist_next = {hist_q[PAT_W-2:0], bit_in};
  assign fill_inc  = (fill_q == LEN_W'(PAT_W)) ? fill_q : fill_q + 1'b1;

  // Select only the low len bits for comparison.
  always_comb begin
    mask = '0;
    for (int i = 0; i < PAT_W; i++) begin
      mask[i] = (i < int'(len));
    end
  end

  assign hit = shift_en && (fill_inc >= len) &&
               (((hist_next ^ pattern) & mask) == '0);

  // Shift history and count fresh bits; non-overlapping mode restarts the count on a hit.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      hist_q <= '0;
      fill_q <= '0;
    end else if (shift_en) begin
      hist_q <= hist_next;
      fill_q <= (hit && !overlap) ? '0 : fill_inc;
    end
  end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Sequence detector controller: configuration registers, run FSM and
// saturating match counter around a seq_matcher datapath.
module seq_detect_ctrl
  import seq_detect_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  seq_detect_ctrl_if.slave     cfg,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 bit_valid,
  input  logic                 bit_in,
  output logic                 busy,
  output logic                 match_pulse,
  output logic [CNT_W-1:0]     match_count,
  output logic                 done,
  output logic                 err_cfg,
  output state_t               state_dbg
);

  localparam int LEN_W = $clog2(PAT_W) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q, state_d;
  logic [PAT_W-1:0] pat_q;
  logic [LEN_W-1:0] len_q;
  logic             ovl_q;
  logic [CNT_W-1:0] tgt_q;
  logic             loaded_q;
  logic             err_q;
  logic             pulse_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] cnt_inc;

  logic cfg_hs;
  logic cfg_ok;
  logic idle_or_done;
  logic start_go;
  logic start_bad;
  logic shift_en;
  logic hit;
  logic tgt_hit;

  assign idle_or_done  = (state_q != ST_ARMED);
  assign cfg.cfg_ready = idle_or_done;
  assign cfg_hs        = cfg.cfg_valid && cfg.cfg_ready;
  assign cfg_ok        = (cfg.cfg_len != '0) && (cfg.cfg_len <= LEN_W'(PAT_W));
  assign start_go      = start && !abort && idle_or_done && loaded_q;
  assign start_bad     = start && !abort && idle_or_done && !loaded_q;
  assign shift_en      = (state_q == ST_ARMED) && bit_valid && !abort;
  assign cnt_inc       = (count_q == CNT_MAX) ? count_q : count_q + 1'b1;
  assign tgt_hit       = (tgt_q != '0) && (cnt_inc == tgt_q);

  seq_matcher #(.PAT_W(PAT_W), .LEN_W(LEN_W)) u_matcher (
    .clk      (clk),
    .rst      (rst),
    .clear    (start_go || abort),
    .shift_en (shift_en),
    .bit_in   (bit_in),
    .overlap  (ovl_q),
    .pattern  (pat_q),
    .len      (len_q),
    .hit      (hit)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; abort overrides every other transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_go) state_d = ST_ARMED;
      ST_ARMED: if (hit && tgt_hit) state_d = ST_DONE;
      ST_DONE:  if (start_go) state_d = ST_ARMED;
      default:  state_d = ST_IDLE;
    endcase
    if (abort) state_d = ST_IDLE;
  end

  // Configuration capture, error flag, match pulse and counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q    <= '0;
      len_q    <= '0;
      ovl_q    <= 1'b0;
      tgt_q    <= '0;
      loaded_q <= 1'b0;
      err_q    <= 1'b0;
      pulse_q  <= 1'b0;
      count_q  <= '0;
    end else begin
      if (cfg_hs) begin
        if (cfg_ok) begin
          pat_q    <= cfg.cfg_pattern;
          len_q    <= cfg.cfg_len;
          ovl_q    <= cfg.cfg_overlap;
          tgt_q    <= cfg.cfg_target;
          loaded_q <= 1'b1;
          err_q    <= 1'b0;
        end else begin
          err_q <= 1'b1;
        end
      end
      if (start_bad) err_q <= 1'b1;
      pulse_q <= hit;
      if (abort || start_go) count_q <= '0;
      else if (hit)          count_q <= cnt_inc;
    end
  end

  assign busy        = (state_q == ST_ARMED);
  assign done        = (state_q == ST_DONE);
  assign match_pulse = pulse_q;
  assign match_count = count_q;
  assign err_cfg     = err_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Bench for seq_detect_ctrl: directed scenarios plus randomized runs,
// checked against a bit-queue reference model through a pulse scoreboard.
module tb_seq_detect_ctrl;
  import seq_detect_pkg::*;

  localparam int PAT_W = 8;
  localparam int CNT_W = 4;
  localparam int LEN_W = $clog2(PAT_W) + 1;
  localparam int W     = 32 + CNT_W;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             bit_valid = 1'b0;
  logic             bit_in = 1'b0;
  logic             busy;
  logic             match_pulse;
  logic [CNT_W-1:0] match_count;
  logic             done;
  logic             err_cfg;
  state_t           state_dbg;

  seq_detect_ctrl_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) cfg_if ();

  seq_detect_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg         (cfg_if),
    .start       (start),
    .abort       (abort),
    .bit_valid   (bit_valid),
    .bit_in      (bit_in),
    .busy        (busy),
    .match_pulse (match_pulse),
    .match_count (match_count),
    .done        (done),
    .err_cfg     (err_cfg),
    .state_dbg   (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int tests = 0;
  int fails = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_e;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Each match pulse must match the next expected {cycle, count} entry.
  always @(negedge clk) begin
    if (!rst && match_pulse) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL pulse_unexpected: pulse at cycle %0d count %0d, none expected", cyc, match_count);
      end else begin
        exp_e = exp_q.pop_front();
        if ({cyc[31:0], match_count} != exp_e) begin
          fails++;
          $display("FAIL pulse: got cycle %0d count %0d expected cycle %0d count %0d",
                   cyc, match_count, exp_e[W-1:CNT_W], exp_e[CNT_W-1:0]);
        end
      end
    end
  end

  // ---------------- reference model ----------------
  state_t           m_st = ST_IDLE;
  int               m_count = 0;
  bit               m_err = 0;
  bit               m_loaded = 0;
  logic [PAT_W-1:0] m_pat = '0;
  int               m_len = 0;
  bit               m_ovl = 0;
  int               m_tgt = 0;
  bit               m_hist[$];

  // Bits received since arming (or since the last non-overlapping match),
  // oldest first; a match means the newest m_len bits spell the pattern.
  task automatic model_bit(input bit b);
    bit ok;
    if (m_st != ST_ARMED) return;
    m_hist.push_back(b);
    if (m_hist.size() > PAT_W) void'(m_hist.pop_front());
    ok = (m_hist.size() >= m_len);
    for (int i = 0; i < m_len && ok; i++)
      if (m_hist[m_hist.size() - 1 - i] != m_pat[i]) ok = 0;
    if (ok) begin
      if (m_count < CNT_MAX) m_count++;
      exp_q.push_back({cyc + 32'd1, CNT_W'(m_count)});
      if (!m_ovl) m_hist.delete();
      if (m_tgt != 0 && m_count == m_tgt) m_st = ST_DONE;
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".busy"},  int'(busy), int'(m_st == ST_ARMED));
    check({tag, ".done"},  int'(done), int'(m_st == ST_DONE));
    check({tag, ".count"}, int'(match_count), m_count);
    check({tag, ".err"},   int'(err_cfg), int'(m_err));
    check({tag, ".state"}, int'(state_dbg), int'(m_st));
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 0; abort = 0; bit_valid = 0; cfg_if.cfg_valid = 0;
    step(); step();
    rst = 1'b0;
    m_st = ST_IDLE; m_count = 0; m_err = 0; m_loaded = 0; m_hist.delete();
    exp_q.delete();
  endtask

  task automatic drive_cfg(input logic [PAT_W-1:0] pat, input int len, input bit ovl, input int tgt);
    cfg_if.cfg_valid   = 1'b1;
    cfg_if.cfg_pattern = pat;
    cfg_if.cfg_len     = LEN_W'(len);
    cfg_if.cfg_overlap = ovl;
    cfg_if.cfg_target  = CNT_W'(tgt);
    if (m_st != ST_ARMED) begin
      if (len >= 1 && len <= PAT_W) begin
        m_pat = pat; m_len = len; m_ovl = ovl; m_tgt = tgt; m_loaded = 1; m_err = 0;
      end else begin
        m_err = 1;
      end
    end
    step();
    cfg_if.cfg_valid = 1'b0;
  endtask

  task automatic drive_start();
    start = 1'b1;
    if (m_st != ST_ARMED) begin
      if (m_loaded) begin
        m_st = ST_ARMED; m_count = 0; m_hist.delete();
      end else begin
        m_err = 1;
      end
    end
    step();
    start = 1'b0;
  endtask

  task automatic drive_abort(input bit with_start);
    abort = 1'b1;
    start = with_start;
    m_st = ST_IDLE; m_count = 0; m_hist.delete();
    step();
    abort = 1'b0;
    start = 1'b0;
  endtask

  task automatic drive_bit(input bit b);
    bit_valid = 1'b1;
    bit_in    = b;
    model_bit(b);
    step();
    bit_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic drive_stream(input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) drive_bit(bits[i]);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    cfg_if.cfg_valid   = 1'b0;
    cfg_if.cfg_pattern = '0;
    cfg_if.cfg_len     = '0;
    cfg_if.cfg_overlap = 1'b0;
    cfg_if.cfg_target  = '0;

    do_reset();
    check_model("reset");
    check("reset.pulse", int'(match_pulse), 0);
    check("reset.cfg_ready", int'(cfg_if.cfg_ready), 1);

    // 10101 overlapping: matches after bits 5 and 7.
    drive_cfg(8'h15, 5, 1, 0);
    drive_start();
    check("armed.cfg_ready", int'(cfg_if.cfg_ready), 0);
    drive_stream(32'b1010101, 7);
    idle(2);
    check_model("ovl");
    check("ovl.count2", int'(match_count), 2);
    drive_abort(0);

    // Same stream non-overlapping: single match.
    drive_cfg(8'h15, 5, 0, 0);
    drive_start();
    drive_stream(32'b1010101, 7);
    idle(2);
    check_model("novl");
    check("novl.count1", int'(match_count), 1);
    drive_abort(0);

    // Target 2 on pattern 11: DONE after third bit, fourth ignored.
    drive_cfg(8'h03, 2, 1, 2);
    drive_start();
    drive_stream(32'b111, 3);
    check("tgt.done", int'(done), 1);
    check("tgt.busy", int'(busy), 0);
    drive_bit(1'b1);
    idle(2);
    check_model("tgt");
    check("tgt.count2", int'(match_count), 2);
    drive_start();
    check_model("tgt_restart");
    drive_abort(0);

    // Reset mid-run discards config; bad lengths flag errors.
    drive_start();
    drive_bit(1'b1);
    do_reset();
    drive_start();
    check_model("nocfg_start");
    check("nocfg.err", int'(err_cfg), 1);
    do_reset();
    drive_cfg(8'h01, 0, 1, 0);
    check("len0.err", int'(err_cfg), 1);
    drive_start();
    check_model("len0_start");
    drive_cfg(8'h01, 3, 1, 0);
    check("good.err_clear", int'(err_cfg), 0);
    drive_cfg(8'h01, 9, 1, 0);
    check("len9.err", int'(err_cfg), 1);

    // Abort and start together while armed.
    drive_cfg(8'h03, 2, 1, 0);
    drive_start();
    drive_stream(32'b11, 2);
    check("pre_abort.count", int'(match_count), 1);
    drive_abort(1);
    check_model("abort_start");

    // Valid-bit gaps.
    drive_cfg(8'h05, 3, 1, 0);
    drive_start();
    drive_bit(1'b1); idle(2);
    drive_bit(1'b0); idle(3);
    drive_bit(1'b1); idle(3);
    check_model("gaps");
    check("gaps.count1", int'(match_count), 1);
    drive_abort(0);

    // Counter saturation.
    drive_cfg(8'h01, 1, 1, 0);
    drive_start();
    repeat (CNT_MAX + 4) drive_bit(1'b1);
    idle(2);
    check_model("sat");
    check("sat.count", int'(match_count), CNT_MAX);
    drive_abort(0);

    // Randomized runs.
    for (int r = 0; r < 30; r++) begin
      int k;
      drive_cfg(PAT_W'($urandom), $urandom_range(0, 9) == 0 ? 0 : $urandom_range(1, 4 + (r % 5)),
                1'($urandom_range(0, 1)), $urandom_range(0, 3));
      check_model("rnd_cfg");
      drive_start();
      check_model("rnd_start");
      for (int i = 0; i < 40; i++) begin
        k = $urandom_range(0, 19);
        if (k < 13)       drive_bit(1'($urandom_range(0, 1)));
        else if (k < 19)  idle(1);
        else              drive_abort($urandom_range(0, 1) == 1);
      end
      idle(2);
      check_model("rnd_end");
      drive_abort(0);
    end

    idle(3);
    check("exp_q_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
